// File: rtl/synth_ctrl_pkg.sv
// Shared constants and address decode for the synthesizer control-register slave.
package synth_ctrl_pkg;

   // Word addresses of the register map
   localparam logic [4:0] ADDR_CTRL    = 5'd0;
   localparam logic [4:0] ADDR_LED     = 5'd1;
   localparam logic [4:0] ADDR_KEYS    = 5'd2;
   localparam logic [4:0] ADDR_EDGE    = 5'd3;
   localparam logic [4:0] ADDR_IRQMASK = 5'd4;
   localparam logic [4:0] ADDR_FX      = 5'd5;
   localparam logic [4:0] ADDR_VOICE0  = 5'd8;

   // CTRL register bit positions
   localparam int CTRL_COMMIT_BIT = 0;
   localparam int CTRL_AUTO_BIT   = 1;

   // Largest supported parameter values
   localparam int MAX_VOICES  = 16;
   localparam int MAX_VOICE_W = 32;
   localparam int MAX_FX_W    = 32;
   localparam int MAX_KEYS    = 8;
   localparam int MAX_LEDS    = 32;

   // Decoded register selected by the current bus address
   typedef enum logic [2:0] {
      REG_NONE,
      REG_CTRL,
      REG_LED,
      REG_KEYS,
      REG_EDGE,
      REG_IRQMASK,
      REG_FX,
      REG_VOICE
   } regSel_e;

   // Maps a word address onto a register class; unmapped addresses give REG_NONE
   function automatic regSel_e decodeAddr(input logic [4:0] addr, input int numVoices);
      regSel_e sel;
      sel = REG_NONE;
      case (addr)
         ADDR_CTRL:    sel = REG_CTRL;
         ADDR_LED:     sel = REG_LED;
         ADDR_KEYS:    sel = REG_KEYS;
         ADDR_EDGE:    sel = REG_EDGE;
         ADDR_IRQMASK: sel = REG_IRQMASK;
         ADDR_FX:      sel = REG_FX;
         default: begin
            if ((int'(addr) >= int'(ADDR_VOICE0)) &&
                (int'(addr) < int'(ADDR_VOICE0) + numVoices))
               sel = REG_VOICE;
         end
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/key_edge_capture.sv
// Key synchroniser, press detector, write-1-to-clear press capture and masked interrupt.
module key_edge_capture #(
   parameter int NUM_KEYS = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NUM_KEYS-1:0] i_keys,
   input  logic                i_edgeClrEn,
   input  logic [NUM_KEYS-1:0] i_edgeClrMask,
   input  logic                i_maskWrEn,
   input  logic [NUM_KEYS-1:0] i_maskData,
   output logic [NUM_KEYS-1:0] o_keyLevel,
   output logic [NUM_KEYS-1:0] o_edge,
   output logic [NUM_KEYS-1:0] o_mask,
   output logic                o_irq
);

   logic [NUM_KEYS-1:0] r_sync1;
   logic [NUM_KEYS-1:0] r_sync2;
   logic [NUM_KEYS-1:0] r_prev;
   logic [NUM_KEYS-1:0] r_edge;
   logic [NUM_KEYS-1:0] r_mask;
   logic                r_irq;
   logic [NUM_KEYS-1:0] w_press;

   // Two-flop synchroniser plus previous-value flop; idle level is released (all ones)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_prev  <= '1;
      end else begin
         r_sync1 <= i_keys;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_press = r_prev & ~r_sync2;

   // Press capture: a new press wins over a simultaneous clear of the same bit
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_edge <= '0;
      end else if (i_edgeClrEn) begin
         r_edge <= (r_edge & ~i_edgeClrMask) | w_press;
      end else begin
         r_edge <= r_edge | w_press;
      end
   end

   // Interrupt mask register and registered interrupt output
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mask <= '0;
         r_irq  <= 1'b0;
      end else begin
         if (i_maskWrEn)
            r_mask <= i_maskData;
         r_irq <= |(r_edge & r_mask);
      end
   end

   assign o_keyLevel = ~r_sync2;
   assign o_edge     = r_edge;
   assign o_mask     = r_mask;
   assign o_irq      = r_irq;

endmodule

// File: rtl/synth_ctrl_regs.sv
// Avalon-MM control registers: LEDs, key capture, and double-buffered voice/effects words
// that move to the sound engine atomically on an audio sample strobe.
module synth_ctrl_regs
   import synth_ctrl_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int VOICE_W    = 11,
   parameter int FX_W       = 18,
   parameter int NUM_KEYS   = 4,
   parameter int NUM_LEDS   = 8
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset_n,
   input  logic [4:0]                    avs_address,
   input  logic                          avs_write,
   input  logic                          avs_read,
   input  logic [31:0]                   avs_writedata,
   output logic [31:0]                   avs_readdata,
   input  logic                          sample_tick,
   input  logic [NUM_KEYS-1:0]           keys_export,
   output logic [NUM_LEDS-1:0]           led_export,
   output logic [FX_W-1:0]               effects_ctrl_bus,
   output logic [NUM_VOICES*VOICE_W-1:0] sound_ctrl_bus,
   output logic                          irq
);

   regSel_e             w_sel;
   logic                w_ctrlWr;
   logic                w_commitReq;
   logic                w_copy;
   logic [31:0]         w_readMux;
   logic [NUM_KEYS-1:0] w_keyLevel;
   logic [NUM_KEYS-1:0] w_edge;
   logic [NUM_KEYS-1:0] w_mask;
   logic                w_unusedWriteData;

   logic                r_pending;
   logic                r_auto;
   logic [NUM_LEDS-1:0] r_led;
   logic [FX_W-1:0]     r_fxShadow;
   logic [FX_W-1:0]     r_fxActive;
   logic [VOICE_W-1:0]  r_voiceShadow [NUM_VOICES];
   logic [VOICE_W-1:0]  r_voiceActive [NUM_VOICES];
   logic [31:0]         r_readdata;

   // Address decode shared by the write and read paths
   always_comb begin
      w_sel = decodeAddr(avs_address, NUM_VOICES);
   end

   assign w_ctrlWr          = avs_write && (w_sel == REG_CTRL);
   assign w_commitReq       = w_ctrlWr && avs_writedata[CTRL_COMMIT_BIT];
   assign w_copy            = sample_tick && (r_pending || r_auto);
   assign w_unusedWriteData = ^avs_writedata;

   // Commit bookkeeping: a new request wins over the clear done by a copy
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_pending <= 1'b0;
         r_auto    <= 1'b0;
      end else begin
         if (w_commitReq)
            r_pending <= 1'b1;
         else if (w_copy)
            r_pending <= 1'b0;
         if (w_ctrlWr)
            r_auto <= avs_writedata[CTRL_AUTO_BIT];
      end
   end

   // LED drive register
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)
         r_led <= '0;
      else if (avs_write && (w_sel == REG_LED))
         r_led <= avs_writedata[NUM_LEDS-1:0];
   end

   // Effects shadow and active words; the copy always sees the pre-write shadow
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_fxShadow <= '0;
         r_fxActive <= '0;
      end else begin
         if (avs_write && (w_sel == REG_FX))
            r_fxShadow <= avs_writedata[FX_W-1:0];
         if (w_copy)
            r_fxActive <= r_fxShadow;
      end
   end

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      localparam logic [4:0] L_VADDR = ADDR_VOICE0 + 5'(v);

      // Per-voice shadow and active word pair
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            r_voiceShadow[v] <= '0;
            r_voiceActive[v] <= '0;
         end else begin
            if (avs_write && (avs_address == L_VADDR))
               r_voiceShadow[v] <= avs_writedata[VOICE_W-1:0];
            if (w_copy)
               r_voiceActive[v] <= r_voiceShadow[v];
         end
      end

      assign sound_ctrl_bus[v*VOICE_W +: VOICE_W] = r_voiceActive[v];
   end

   // Read multiplexer built from registered state only, so same-cycle writes read old data
   always_comb begin
      w_readMux = '0;
      case (w_sel)
         REG_CTRL: begin
            w_readMux[CTRL_COMMIT_BIT] = r_pending;
            w_readMux[CTRL_AUTO_BIT]   = r_auto;
         end
         REG_LED:     w_readMux = 32'(r_led);
         REG_KEYS:    w_readMux = 32'(w_keyLevel);
         REG_EDGE:    w_readMux = 32'(w_edge);
         REG_IRQMASK: w_readMux = 32'(w_mask);
         REG_FX:      w_readMux = 32'(r_fxShadow);
         REG_VOICE: begin
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (avs_address == (ADDR_VOICE0 + 5'(v)))
                  w_readMux = 32'(r_voiceShadow[v]);
            end
         end
         default:     w_readMux = '0;
      endcase
   end

   // Fixed one-cycle read latency; the data bus idles at zero between reads
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)
         r_readdata <= '0;
      else
         r_readdata <= avs_read ? w_readMux : 32'd0;
   end

   key_edge_capture #(
      .NUM_KEYS(NUM_KEYS)
   ) u_keys (
      .i_clk         (clk_clk),
      .i_rst_n       (reset_reset_n),
      .i_keys        (keys_export),
      .i_edgeClrEn   (avs_write && (w_sel == REG_EDGE)),
      .i_edgeClrMask (avs_writedata[NUM_KEYS-1:0]),
      .i_maskWrEn    (avs_write && (w_sel == REG_IRQMASK)),
      .i_maskData    (avs_writedata[NUM_KEYS-1:0]),
      .o_keyLevel    (w_keyLevel),
      .o_edge        (w_edge),
      .o_mask        (w_mask),
      .o_irq         (irq)
   );

   assign avs_readdata     = r_readdata;
   assign led_export       = r_led;
   assign effects_ctrl_bus = r_fxActive;

endmodule

// File: tb/tb_synth_ctrl_regs.sv
// Self-checking bench for synth_ctrl_regs with default parameters.
module tb_synth_ctrl_regs;

   logic        clk_clk;
   logic        reset_reset_n;
   logic [4:0]  avs_address;
   logic        avs_write;
   logic        avs_read;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic        sample_tick;
   logic [3:0]  keys_export;
   logic [7:0]  led_export;
   logic [17:0] effects_ctrl_bus;
   logic [87:0] sound_ctrl_bus;
   logic        irq;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]  addr;
      bit          doWrite;
      logic [31:0] wdata;
      logic [31:0] expRead;
      string       name;
   } vec_t;

   vec_t vecs[$];

   // Reference model state for the randomized phase
   int unsigned mShadow [8];
   int unsigned mActive [8];
   int unsigned mFx, mFxAct, mLed, mMask;
   bit          mPend, mAuto;

   synth_ctrl_regs dut (
      .clk_clk          (clk_clk),
      .reset_reset_n    (reset_reset_n),
      .avs_address      (avs_address),
      .avs_write        (avs_write),
      .avs_read         (avs_read),
      .avs_writedata    (avs_writedata),
      .avs_readdata     (avs_readdata),
      .sample_tick      (sample_tick),
      .keys_export      (keys_export),
      .led_export       (led_export),
      .effects_ctrl_bus (effects_ctrl_bus),
      .sound_ctrl_bus   (sound_ctrl_bus),
      .irq              (irq)
   );

   // Free-running 100 MHz clock
   initial begin
      clk_clk = 1'b0;
      forever #5 clk_clk = ~clk_clk;
   end

   // Safety net so the run always terminates
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives one bus cycle from a falling edge and returns at the next falling edge
   task automatic applyStimulus(input logic [4:0] a, input bit w, input logic [31:0] d,
                                input bit r, input bit t);
      avs_address   = a;
      avs_write     = w;
      avs_writedata = d;
      avs_read      = r;
      sample_tick   = t;
      @(negedge clk_clk);
      avs_write   = 1'b0;
      avs_read    = 1'b0;
      sample_tick = 1'b0;
   endtask

   task automatic wrReg(input logic [4:0] a, input logic [31:0] d);
      applyStimulus(a, 1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic rdCheck(input string name, input logic [4:0] a, input logic [31:0] exp);
      applyStimulus(a, 1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput(name, avs_readdata, exp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      avs_write   = 1'b0;
      avs_read    = 1'b0;
      sample_tick = 1'b0;
      reset_reset_n = 1'b0;
      repeat (2) @(negedge clk_clk);
      reset_reset_n = 1'b1;
   endtask

   function automatic logic [31:0] modelRead(input logic [4:0] a);
      int ai;
      ai = int'(a);
      if (ai == 0) return {30'd0, mAuto, mPend};
      if (ai == 1) return mLed;
      if (ai == 4) return mMask;
      if (ai == 5) return mFx;
      if (ai >= 8 && ai < 16) return mShadow[ai-8];
      return 32'd0;
   endfunction

   function automatic logic [87:0] modelBus();
      logic [87:0] e;
      e = '0;
      for (int v = 0; v < 8; v++)
         e = e | (88'(mActive[v]) << (v * 11));
      return e;
   endfunction

   initial begin
      logic [31:0] expRd;
      logic [4:0]  a;
      logic [31:0] d;
      bit          w, r, t, copy;
      int          sel;
      logic [10:0] expV0;

      avs_address   = '0;
      avs_write     = 1'b0;
      avs_read      = 1'b0;
      avs_writedata = '0;
      sample_tick   = 1'b0;
      keys_export   = 4'hF;
      reset_reset_n = 1'b0;
      #1;
      checkOutput("rst_readdata", avs_readdata, 0);
      checkOutput("rst_sound", sound_ctrl_bus, 0);
      checkOutput("rst_fx", effects_ctrl_bus, 0);
      checkOutput("rst_led", led_export, 0);
      checkOutput("rst_irq", irq, 0);
      @(negedge clk_clk);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;

      // Register map vectors: write (optional) then read back
      vecs.push_back('{5'd1,  1'b1, 32'h0000_01A5, 32'h0000_00A5, "led_trunc"});
      vecs.push_back('{5'd4,  1'b1, 32'hFFFF_FFF6, 32'h0000_0006, "mask_trunc"});
      vecs.push_back('{5'd5,  1'b1, 32'hFFFF_FFFF, 32'h0003_FFFF, "fx_trunc"});
      vecs.push_back('{5'd8,  1'b1, 32'hFFFF_F800, 32'h0000_0000, "voice0_trunc"});
      vecs.push_back('{5'd15, 1'b1, 32'h0000_0ABC, 32'h0000_02BC, "voice7"});
      vecs.push_back('{5'd16, 1'b1, 32'h0000_1234, 32'h0000_0000, "voice_oob"});
      vecs.push_back('{5'd6,  1'b1, 32'h0000_FFFF, 32'h0000_0000, "addr6"});
      vecs.push_back('{5'd31, 1'b0, 32'h0000_0000, 32'h0000_0000, "addr31"});
      vecs.push_back('{5'd2,  1'b0, 32'h0000_0000, 32'h0000_0000, "keys_idle"});
      vecs.push_back('{5'd3,  1'b1, 32'h0000_000F, 32'h0000_0000, "edge_idle"});
      vecs.push_back('{5'd0,  1'b1, 32'h0000_0002, 32'h0000_0002, "ctrl_auto"});
      vecs.push_back('{5'd0,  1'b1, 32'h0000_0000, 32'h0000_0000, "ctrl_clear"});
      foreach (vecs[i]) begin
         if (vecs[i].doWrite)
            wrReg(vecs[i].addr, vecs[i].wdata);
         rdCheck(vecs[i].name, vecs[i].addr, vecs[i].expRead);
      end
      checkOutput("table_bus_idle", sound_ctrl_bus, 0);
      doReset();

      // Shadow writes without a commit stay invisible
      wrReg(5'd11, 32'h5A5);
      wrReg(5'd5, 32'h2ABCD);
      applyStimulus(5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      checkOutput("nocommit_sound", sound_ctrl_bus, 0);
      checkOutput("nocommit_fx", effects_ctrl_bus, 0);
      rdCheck("voice3_shadow", 5'd11, 32'h5A5);

      // Commit then a later tick copies everything at once
      wrReg(5'd0, 32'h1);
      rdCheck("ctrl_pending", 5'd0, 32'h1);
      idle(8);
      applyStimulus(5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      checkOutput("commit_voice3", sound_ctrl_bus[43:33], 11'h5A5);
      checkOutput("commit_fx", effects_ctrl_bus, 18'h2ABCD);
      rdCheck("ctrl_after_commit", 5'd0, 32'h0);

      // Commit coincident with a tick waits for the next tick
      wrReg(5'd11, 32'h111);
      applyStimulus(5'd0, 1'b1, 32'h1, 1'b0, 1'b1);
      checkOutput("coincident_commit", sound_ctrl_bus[43:33], 11'h5A5);
      applyStimulus(5'd11, 1'b1, 32'h222, 1'b0, 1'b1);
      checkOutput("copy_prewrite", sound_ctrl_bus[43:33], 11'h111);
      rdCheck("voice3_newshadow", 5'd11, 32'h222);
      rdCheck("ctrl_cleared", 5'd0, 32'h0);

      // Key press capture and interrupt timing
      wrReg(5'd1, 32'h3C);
      wrReg(5'd4, 32'h4);
      keys_export[2] = 1'b0;
      idle(3);
      checkOutput("irq_not_yet", irq, 0);
      idle(1);
      checkOutput("irq_set", irq, 1);
      rdCheck("edge_captured", 5'd3, 32'h4);
      rdCheck("keys_level", 5'd2, 32'h4);
      wrReg(5'd3, 32'h4);
      idle(1);
      checkOutput("irq_cleared", irq, 0);
      rdCheck("edge_w1c", 5'd3, 32'h0);
      keys_export = 4'hF;
      idle(4);
      keys_export[2] = 1'b0;
      idle(2);
      wrReg(5'd3, 32'h4);
      rdCheck("edge_press_wins", 5'd3, 32'h4);
      checkOutput("irq_again", irq, 1);
      keys_export = 4'hF;

      // Auto mode: each tick publishes the shadow value held before that cycle
      wrReg(5'd0, 32'h2);
      expV0 = 11'd0;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 1) expV0 = 11'(i);
         applyStimulus(5'd8, 1'b1, 32'(i + 1), 1'b0, (i % 2 == 1));
         checkOutput($sformatf("auto_v0_%0d", i), sound_ctrl_bus[10:0], expV0);
      end
      rdCheck("ctrl_auto_on", 5'd0, 32'h2);
      rdCheck("addr31_zero", 5'd31, 32'h0);

      // Reset in the middle of a pending commit
      wrReg(5'd0, 32'h1);
      rdCheck("ctrl_pending_prereset", 5'd0, 32'h1);
      #2 reset_reset_n = 1'b0;
      #1;
      checkOutput("async_rst_sound", sound_ctrl_bus, 0);
      checkOutput("async_rst_fx", effects_ctrl_bus, 0);
      checkOutput("async_rst_led", led_export, 0);
      checkOutput("async_rst_irq", irq, 0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      applyStimulus(5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      checkOutput("postrst_nocopy", sound_ctrl_bus, 0);
      rdCheck("postrst_ctrl", 5'd0, 32'h0);

      // Randomized traffic against the reference model
      doReset();
      for (int v = 0; v < 8; v++) begin
         mShadow[v] = 0;
         mActive[v] = 0;
      end
      mFx = 0; mFxAct = 0; mLed = 0; mMask = 0; mPend = 0; mAuto = 0;
      for (int n = 0; n < 300; n++) begin
         sel = int'($urandom_range(0, 2));
         if (sel == 0)      a = 5'($urandom_range(0, 31));
         else if (sel == 1) a = 5'($urandom_range(8, 15));
         else               a = 5'($urandom_range(0, 5));
         w = bit'($urandom_range(0, 1));
         r = bit'($urandom_range(0, 1));
         t = ($urandom_range(0, 4) == 0);
         d = $urandom;
         if (a == 5'd0)
            d = (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0) | 32'($urandom_range(0, 1));

         expRd = r ? modelRead(a) : 32'd0;
         copy = t && (mAuto || mPend);
         if (copy) begin
            for (int v = 0; v < 8; v++) mActive[v] = mShadow[v];
            mFxAct = mFx;
         end
         if (w && a == 5'd0 && d[0]) mPend = 1'b1;
         else if (copy)              mPend = 1'b0;
         if (w) begin
            if (a == 5'd0) mAuto = d[1];
            if (a == 5'd1) mLed  = d % 256;
            if (a == 5'd4) mMask = d % 16;
            if (a == 5'd5) mFx   = d % (1 << 18);
            if (int'(a) >= 8 && int'(a) < 16) mShadow[int'(a) - 8] = d % 2048;
         end

         applyStimulus(a, w, d, r, t);
         checkOutput($sformatf("rnd%0d_sound", n), sound_ctrl_bus, modelBus());
         checkOutput($sformatf("rnd%0d_fx", n), effects_ctrl_bus, mFxAct);
         checkOutput($sformatf("rnd%0d_read", n), avs_readdata, expRd);
         checkOutput($sformatf("rnd%0d_led", n), led_export, mLed);
         checkOutput($sformatf("rnd%0d_irq", n), irq, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
